// File: rtl/rect_box_overlay.sv
// Latches the detector's bounding box at each frame start and paints a THICK-pixel
// border of BOX_COLOR onto the RGB565 stream through a registered 1-cycle stage.
module rect_box_overlay #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] BOX_COLOR = 16'hF800,
  parameter int                THICK     = 2,
  parameter int                IMG_W     = 640,
  parameter int                IMG_H     = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic              in_clken,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rect_flag,
  input  logic [9:0]        rect_up,
  input  logic [9:0]        rect_down,
  input  logic [9:0]        rect_left,
  input  logic [9:0]        rect_right,
  output logic              out_vsync,
  output logic              out_href,
  output logic              out_clken,
  output logic [DATA_W-1:0] out_data,
  output logic              box_active
);

  localparam logic [10:0] TM1  = 11'(THICK - 1);
  localparam logic [9:0]  XMAX = 10'(IMG_W - 1);
  localparam logic [9:0]  YMAX = 10'(IMG_H - 1);

  logic              vs_prev_q, href_prev_q;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [9:0]        up_q, down_q, left_q, right_q;
  logic              active_q;
  logic              vsync_q, href_q, clken_q;
  logic [DATA_W-1:0] data_q, data_d;

  logic        vs_rise, href_fall, pix;
  logic [10:0] x11, y11, up11, down11, left11, right11;
  logic        in_rows, in_cols, edge_v, edge_h;

  always_comb begin
    vs_rise   = in_vsync & ~vs_prev_q;
    href_fall = href_prev_q & ~in_href;
    pix       = in_href & in_clken;

    x11     = {1'b0, x_q};
    y11     = {1'b0, y_q};
    up11    = {1'b0, up_q};
    down11  = {1'b0, down_q};
    left11  = {1'b0, left_q};
    right11 = {1'b0, right_q};

    // Both edge terms are gated by the full box extent so nothing outside the box is painted;
    // a box thinner than 2*THICK falls out of these tests completely filled.
    in_rows = (y11 >= up11) && (y11 <= down11);
    in_cols = (x11 >= left11) && (x11 <= right11);
    edge_v  = in_rows && in_cols && ((x11 <= left11 + TM1) || (x11 + TM1 >= right11));
    edge_h  = in_rows && in_cols && ((y11 <= up11 + TM1) || (y11 + TM1 >= down11));

    x_d = x_q;
    if (href_fall)                x_d = '0;
    else if (pix && (x_q < XMAX)) x_d = x_q + 10'd1;

    // Frame restart beats the line advance when both land on the same cycle.
    y_d = y_q;
    if (vs_rise)                        y_d = '0;
    else if (href_fall && (y_q < YMAX)) y_d = y_q + 10'd1;

    data_d = '0;
    if (in_href) data_d = (active_q && pix && (edge_v || edge_h)) ? BOX_COLOR : in_data;
  end

  // vs_prev_q resets high so a frame already in progress at reset release is not mistaken
  // for a new frame start; drawing resumes only after a genuine low-to-high vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q   <= 1'b1;
      href_prev_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      up_q        <= '0;
      down_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      active_q    <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      clken_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      vs_prev_q   <= in_vsync;
      href_prev_q <= in_href;
      x_q         <= x_d;
      y_q         <= y_d;
      if (vs_rise) begin
        up_q     <= rect_up;
        down_q   <= rect_down;
        left_q   <= rect_left;
        right_q  <= rect_right;
        active_q <= rect_flag && (rect_up <= rect_down) && (rect_left <= rect_right);
      end
      vsync_q <= in_vsync;
      href_q  <= in_href;
      clken_q <= in_clken;
      data_q  <= data_d;
    end
  end

  assign out_vsync  = vsync_q;
  assign out_href   = href_q;
  assign out_clken  = clken_q;
  assign out_data   = data_q;
  assign box_active = active_q;

endmodule
